// File: rtl/ex_mem_pipe_ctrl.sv
// EX->MEM pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module ex_mem_pipe_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load_in,
  input  logic             store_in,
  input  logic             reg_write_in,
  input  logic [1:0]       mem_reg_in,
  input  logic [XLEN-1:0]  opb_datain,
  input  logic [XLEN-1:0]  alu_res,
  input  logic [XLEN-1:0]  next_sel_addr,
  input  logic [XLEN-1:0]  pre_address_in,
  input  logic [XLEN-1:0]  instruction_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             load_out,
  output logic             store_out,
  output logic             reg_write_out,
  output logic [1:0]       mem_reg_out,
  output logic [XLEN-1:0]  opb_dataout,
  output logic [XLEN-1:0]  alu_res_out,
  output logic [XLEN-1:0]  next_sel_address,
  output logic [XLEN-1:0]  pre_address_out,
  output logic [XLEN-1:0]  instruction_out,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned PW = 5 + 5 * XLEN;

  logic [PW-1:0]    in_pay;
  logic [PW-1:0]    main_q, main_d;
  logic [PW-1:0]    skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, emit;
  logic             ld_raw, st_raw, rw_raw;
  logic [1:0]       mr_raw;

  assign in_pay = {load_in, store_in, reg_write_in, mem_reg_in, opb_datain, alu_res,
                   next_sel_addr, pre_address_in, instruction_in};

  // With the skid buffer, in_ready depends only on state, breaking the out_ready path.
  assign in_ready = SKID_EN ? !skid_valid_q : (out_ready | !main_valid_q);
  assign accept   = in_valid & in_ready;
  assign emit     = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (emit) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_pay;
      end
    end else if (!main_valid_q) begin
      main_valid_d = accept;
      if (accept) main_d = in_pay;
    end else if (accept && SKID_EN) begin
      skid_d       = in_pay;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  assign {ld_raw, st_raw, rw_raw, mr_raw, opb_dataout, alu_res_out, next_sel_address,
          pre_address_out, instruction_out} = main_q;

  // Controls are masked so a flushed or empty slot is an inert bubble.
  assign out_valid     = main_valid_q;
  assign load_out      = ld_raw & main_valid_q;
  assign store_out     = st_raw & main_valid_q;
  assign reg_write_out = rw_raw & main_valid_q;
  assign mem_reg_out   = mr_raw & {2{main_valid_q}};
  assign stall_cnt     = stall_q;

endmodule
